pipe_ctrl_decoder: RTL

Registered main-control decoder for the 5-stage MIPS pipeline, successor to the single-cycle combinational decoder. It decodes the ID-stage instruction and latches the control bundle into the ID/EX register. It detects load-use hazards against the instruction in EX and inserts a parametrised number of bubbles. It handles branch/jump flush and flags illegal opcodes. The opcode set extends to bne, ori, lui, j and jal.

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/load_use_detect.sv | 20 ++
 rtl/pipe_ctrl_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, ALU op codes and EX control bundle for the pipelined MIPS decoder
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int ALUOP_RTYPE = 0;
   localparam int ALUOP_MEM   = 1;
   localparam int ALUOP_BR    = 2;
   localparam int ALUOP_ADDI  = 3;
   localparam int ALUOP_SLTI  = 4;
   localparam int ALUOP_ORI   = 5;
   localparam int ALUOP_LUI   = 6;

   typedef struct packed {
      logic reg_write;
      logic alu_src;
      logic reg_dst;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic branch_ne;
      logic jump;
      logic link;
   } ctrl_t;

   // Opcodes whose rt field is a source operand rather than only a destination.
   function automatic logic reads_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX load and ID sources
module load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_wreg_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_reads_rt_i,
   output logic              hazard_o
);

   logic wreg_live;

   assign wreg_live = ex_valid_i && ex_mem_read_i && (ex_wreg_i != '0);
   assign hazard_o  = wreg_live &&
                      ((ex_wreg_i == id_rs_i) || (id_reads_rt_i && (ex_wreg_i == id_rt_i)));

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// rtl/pipe_ctrl_decoder.sv - registered main-control decoder with load-use stall and flush for ID/EX
module pipe_ctrl_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W      = 3,
   parameter int REG_AW       = 5,
   parameter int STALL_CYCLES = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [31:0]        instr_i,
   input  logic               instr_valid_i,
   input  logic               flush_i,
   output logic               id_ready_o,
   output logic               ex_valid_o,
   output logic               ex_RegWrite_o,
   output logic               ex_ALUSrc_o,
   output logic               ex_RegDst_o,
   output logic               ex_MemtoReg_o,
   output logic               ex_MemRead_o,
   output logic               ex_MemWrite_o,
   output logic               ex_Branch_o,
   output logic               ex_BranchNe_o,
   output logic               ex_Jump_o,
   output logic               ex_Link_o,
   output logic [ALUOP_W-1:0] ex_ALUop_o,
   output logic [REG_AW-1:0]  ex_rs_o,
   output logic [REG_AW-1:0]  ex_rt_o,
   output logic [REG_AW-1:0]  ex_wreg_o,
   output logic               illegal_o
);

   localparam int CNT_W = 2;

   logic [5:0]        op;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic              unused_instr_bits;

   ctrl_t              ctrl_dec;
   logic [ALUOP_W-1:0] aluop_dec;
   logic [REG_AW-1:0]  wreg_dec;
   logic               known_op;

   logic              hazard_raw;
   logic              hazard;
   logic              stall;
   logic              issue;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   ctrl_t              ex_ctrl_q, ex_ctrl_d;
   logic [ALUOP_W-1:0] ex_aluop_q, ex_aluop_d;
   logic               ex_valid_q, ex_valid_d;
   logic [REG_AW-1:0]  ex_rs_q, ex_rs_d;
   logic [REG_AW-1:0]  ex_rt_q, ex_rt_d;
   logic [REG_AW-1:0]  ex_wreg_q, ex_wreg_d;
   logic               illegal_q, illegal_d;

   assign op    = instr_i[31:26];
   assign id_rs = REG_AW'(instr_i[25:21]);
   assign id_rt = REG_AW'(instr_i[20:16]);
   assign id_rd = REG_AW'(instr_i[15:11]);
   assign unused_instr_bits = ^instr_i[10:0];

   always_comb begin
      ctrl_dec  = '0;
      aluop_dec = '0;
      known_op  = 1'b1;
      case (op)
         OP_RTYPE: begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.reg_dst   = 1'b1;
            aluop_dec          = ALUOP_W'(ALUOP_RTYPE);
         end
         OP_LW: begin
            ctrl_dec.reg_write  = 1'b1;
            ctrl_dec.alu_src    = 1'b1;
            ctrl_dec.mem_to_reg = 1'b1;
            ctrl_dec.mem_read   = 1'b1;
            aluop_dec           = ALUOP_W'(ALUOP_MEM);
         end
         OP_SW: begin
            ctrl_dec.alu_src   = 1'b1;
            ctrl_dec.mem_write = 1'b1;
            aluop_dec          = ALUOP_W'(ALUOP_MEM);
         end
         OP_BEQ: begin
            ctrl_dec.branch = 1'b1;
            aluop_dec       = ALUOP_W'(ALUOP_BR);
         end
         OP_BNE: begin
            ctrl_dec.branch    = 1'b1;
            ctrl_dec.branch_ne = 1'b1;
            ctrl_dec.reg_dst   = 1'b1;
            aluop_dec          = ALUOP_W'(ALUOP_BR);
         end
         OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
            case (op)
               OP_ADDI: aluop_dec = ALUOP_W'(ALUOP_ADDI);
               OP_SLTI: aluop_dec = ALUOP_W'(ALUOP_SLTI);
               OP_ORI:  aluop_dec = ALUOP_W'(ALUOP_ORI);
               default: aluop_dec = ALUOP_W'(ALUOP_LUI);
            endcase
         end
         OP_J: begin
            ctrl_dec.jump = 1'b1;
         end
         OP_JAL: begin
            ctrl_dec.jump      = 1'b1;
            ctrl_dec.link      = 1'b1;
            ctrl_dec.reg_write = 1'b1;
         end
         default: known_op = 1'b0;
      endcase
   end

   assign wreg_dec = (op == OP_RTYPE) ? id_rd :
                     (op == OP_JAL)   ? {REG_AW{1'b1}} : id_rt;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use (
      .ex_valid_i    (ex_valid_q),
      .ex_mem_read_i (ex_ctrl_q.mem_read),
      .ex_wreg_i     (ex_wreg_q),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .id_reads_rt_i (reads_rt(op)),
      .hazard_o      (hazard_raw)
   );

   // While the counter runs the held instruction is not re-checked; the bubbles have drained the load.
   assign hazard     = instr_valid_i && (cnt_q == '0) && hazard_raw;
   assign stall      = hazard || (cnt_q != '0);
   assign id_ready_o = !stall || flush_i;
   assign issue      = instr_valid_i && !flush_i && !stall;

   always_comb begin
      cnt_d = '0;
      if (flush_i) begin
         cnt_d = '0;
      end else if (hazard) begin
         cnt_d = CNT_W'(STALL_CYCLES - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end

      ex_ctrl_d  = '0;
      ex_aluop_d = '0;
      ex_valid_d = 1'b0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_wreg_d  = '0;
      illegal_d  = 1'b0;
      if (issue) begin
         ex_valid_d = 1'b1;
         ex_rs_d    = id_rs;
         ex_rt_d    = id_rt;
         ex_wreg_d  = wreg_dec;
         if (known_op) begin
            ex_ctrl_d  = ctrl_dec;
            ex_aluop_d = aluop_dec;
         end else begin
            illegal_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         ex_ctrl_q  <= '0;
         ex_aluop_q <= '0;
         ex_valid_q <= 1'b0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_wreg_q  <= '0;
         illegal_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         ex_ctrl_q  <= ex_ctrl_d;
         ex_aluop_q <= ex_aluop_d;
         ex_valid_q <= ex_valid_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_wreg_q  <= ex_wreg_d;
         illegal_q  <= illegal_d;
      end
   end

   assign ex_valid_o    = ex_valid_q;
   assign ex_RegWrite_o = ex_ctrl_q.reg_write;
   assign ex_ALUSrc_o   = ex_ctrl_q.alu_src;
   assign ex_RegDst_o   = ex_ctrl_q.reg_dst;
   assign ex_MemtoReg_o = ex_ctrl_q.mem_to_reg;
   assign ex_MemRead_o  = ex_ctrl_q.mem_read;
   assign ex_MemWrite_o = ex_ctrl_q.mem_write;
   assign ex_Branch_o   = ex_ctrl_q.branch;
   assign ex_BranchNe_o = ex_ctrl_q.branch_ne;
   assign ex_Jump_o     = ex_ctrl_q.jump;
   assign ex_Link_o     = ex_ctrl_q.link;
   assign ex_ALUop_o    = ex_aluop_q;
   assign ex_rs_o       = ex_rs_q;
   assign ex_rt_o       = ex_rt_q;
   assign ex_wreg_o     = ex_wreg_q;
   assign illegal_o     = illegal_q;

endmodule
